// File: rtl/drp_pkg.sv
// -----------------------------------------------------------------------------
// drp_pkg
// Shared definitions for the DRP (dithered relatively prime) interleaver family:
//   - state_t        : interleaver stream FSM states
//   - drp_we/ws/wp/wa/wc : derived field widths (never below 1 bit)
//   - drp_off        : per-lane edge offset OFF_l = (DRP_p*l) mod E
//   - drp_step       : per-cycle base increment STEP = (DRP_p*z) mod E
//   - drp_cfg_ok     : elaboration-time legality check of the parameter set
// -----------------------------------------------------------------------------
package drp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int drp_clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    // Edge index width.
    function automatic int drp_we(input int fo, input int p);
        return drp_clog2_min1(fo * p);
    endfunction

    // Seed port width: one bit wider than an edge index so that out-of-range
    // seeds (seed >= E) can be presented and flagged even when E is a power of 2.
    function automatic int drp_ws(input int fo, input int p);
        return drp_we(fo, p) + 1;
    endfunction

    function automatic int drp_wp(input int p);
        return drp_clog2_min1(p);
    endfunction

    function automatic int drp_wa(input int p, input int z);
        return drp_clog2_min1(p / z);
    endfunction

    function automatic int drp_wc(input int fo, input int p, input int z);
        return drp_clog2_min1((fo * p) / z);
    endfunction

    function automatic int drp_off(input int drp_p, input int l, input int e);
        return (drp_p * l) % e;
    endfunction

    function automatic int drp_step(input int drp_p, input int z, input int e);
        return (drp_p * z) % e;
    endfunction

    function automatic int drp_gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Legal set: z divides p, 1 <= DRP_p < E, DRP_p coprime to E (and so to z, p).
    function automatic bit drp_cfg_ok(input int fo, input int p, input int z, input int drp_p);
        int e;
        e = fo * p;
        if (fo < 1 || p < 1 || z < 1) return 1'b0;
        if ((p % z) != 0) return 1'b0;
        if (drp_p < 1 || drp_p >= e) return 1'b0;
        if (drp_gcd(drp_p, e) != 1) return 1'b0;
        if (drp_gcd(drp_p, z) != 1) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/drp_bank_decoder.sv
// -----------------------------------------------------------------------------
// drp_bank_decoder
// Combinational routing of z neuron indices (one per lane) to the per-bank
// address package. Lane neuron n lives in bank n mod z at address n / z.
// The lanes of one beat are assumed to hit distinct banks; each bank slot
// takes the address of the lane that targets it (0 if none does).
//
// Ports:
//   memory_index     in  WP*z  lane l neuron index in [l*WP +: WP]
//   address_package  out WA*z  bank b address in [b*WA +: WA]
// -----------------------------------------------------------------------------
module drp_bank_decoder
    import drp_pkg::*;
#(
    parameter  int p  = 16,
    parameter  int z  = 8,
    localparam int WP = drp_wp(p),
    localparam int WA = drp_wa(p, z)
) (
    input  logic [WP*z-1:0] memory_index,
    output logic [WA*z-1:0] address_package
);

    always_comb begin
        address_package = '0;
        for (int b = 0; b < z; b++) begin
            for (int l = 0; l < z; l++) begin
                if ((int'(memory_index[l*WP +: WP]) % z) == b) begin
                    address_package[b*WA +: WA] = WA'(int'(memory_index[l*WP +: WP]) / z);
                end
            end
        end
    end

endmodule

// File: rtl/drp_interleaver_stream.sv
// -----------------------------------------------------------------------------
// drp_interleaver_stream
// Sequential DRP edge interleaver. On start it streams the C = fo*p/z cycles of
// a junction; beat c carries, for lane l, the neuron of edge e = c*z + l under
// pi(e) = (s + DRP_p*e) mod E, plus the per-bank address package. The base
// b_c = (s + DRP_p*z*c) mod E is advanced incrementally by a constant STEP, and
// each lane adds an elaboration constant OFF_l; both use a single conditional
// subtract of E, so there are no multipliers in the datapath.
//
// Optional feature macro: DRP_DITHER_EN
//   defined   : output lane l carries the result of lane (l + cycle) mod z
//               (barrel rotate); address_package is unaffected.
//   undefined : lane l carries edge c*z + l, no rotator.
//
// Ports:
//   clk              in   1     clock
//   reset            in   1     synchronous, active-high
//   start            in   1     begin a pass (sampled only in IDLE)
//   seed             in   WE+1  RP offset s, captured with start
//   out_ready        in   1     consumer accepts the beat
//   out_valid        out  1     beat valid
//   out_last         out  1     beat is cycle C-1
//   cycle_index      out  WC    cycle number of current beat
//   memory_index     out  WP*z  lane l neuron in [l*WP +: WP]
//   address_package  out  WA*z  bank b address in [b*WA +: WA]
//   busy             out  1     not in IDLE
//   done             out  1     pulse after the last beat is accepted
//   seed_err         out  1     pulse when start is taken with seed >= E
// -----------------------------------------------------------------------------
module drp_interleaver_stream
    import drp_pkg::*;
#(
    parameter  int fo    = 2,
    parameter  int p     = 16,
    parameter  int z     = 8,
    parameter  int DRP_p = 5,
    localparam int E     = fo * p,
    localparam int C     = E / z,
    localparam int WE    = drp_we(fo, p),
    localparam int WS    = drp_ws(fo, p),
    localparam int WP    = drp_wp(p),
    localparam int WA    = drp_wa(p, z),
    localparam int WC    = drp_wc(fo, p, z)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WS-1:0]   seed,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            out_last,
    output logic [WC-1:0]   cycle_index,
    output logic [WP*z-1:0] memory_index,
    output logic [WA*z-1:0] address_package,
    output logic            busy,
    output logic            done,
    output logic            seed_err
);

    if (!drp_cfg_ok(fo, p, z, DRP_p)) begin : g_cfg_bad
        $error("drp_interleaver_stream: illegal parameter set (need z | p, gcd(DRP_p, E) = 1, 1 <= DRP_p < E)");
    end

    localparam logic [WE:0]   E_V    = (WE+1)'(E);
    localparam logic [WE:0]   P_V    = (WE+1)'(p);
    localparam logic [WE:0]   STEP_V = (WE+1)'(drp_step(DRP_p, z, E));
    localparam logic [WC-1:0] LAST_C = WC'(C - 1);

    state_t          state_q;
    state_t          state_d;
    logic [WE-1:0]   base_q;
    logic            load;
    logic            adv;
    logic            fin;
    logic            bad_seed;
    logic [WE:0]     base_sum;
    logic [WE-1:0]   base_adv;
    logic [WE-1:0]   base_nxt;
    logic [WC-1:0]   cyc_nxt;
    logic [WP*z-1:0] lane_nrn;
    logic [WP*z-1:0] mi_nxt;
    logic [WA*z-1:0] ap_nxt;

    // seed is one bit wider than an edge index, so the compare is exact.
    assign bad_seed = (seed >= WS'(E_V));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // out_valid is high throughout RUN, so out_ready alone is the handshake.
                if (out_ready) begin
                    if (cycle_index == LAST_C) begin
                        fin     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Incremental base update: b_{c+1} = (b_c + STEP) mod E.
    assign base_sum = {1'b0, base_q} + STEP_V;
    assign base_adv = (base_sum >= E_V) ? WE'(base_sum - E_V) : WE'(base_sum);
    assign base_nxt = load ? (bad_seed ? '0 : seed[WE-1:0]) : base_adv;
    assign cyc_nxt  = load ? '0 : cycle_index + WC'(1);

    // Per-lane pi = (b + OFF_l) mod E, then neuron = pi mod p.
    for (genvar l = 0; l < z; l++) begin : g_lane
        localparam logic [WE:0] OFF = (WE+1)'(drp_off(DRP_p, l, E));
        logic [WE:0] sum;
        logic [WE:0] pi;
        assign sum = {1'b0, base_nxt} + OFF;
        assign pi  = (sum >= E_V) ? sum - E_V : sum;
        assign lane_nrn[l*WP +: WP] = WP'(pi % P_V);
    end

`ifdef DRP_DITHER_EN
    // Write dither: output lane l takes lane (l + cycle) mod z. A rotation keeps
    // the set of banks per beat unchanged, so the beat stays clash-free.
    always_comb begin
        mi_nxt = '0;
        for (int l = 0; l < z; l++) begin
            mi_nxt[l*WP +: WP] = lane_nrn[((l + int'(cyc_nxt)) % z)*WP +: WP];
        end
    end
`else
    assign mi_nxt = lane_nrn;
`endif

    // Bank routing depends only on the lane set, so the unrotated lanes feed it.
    drp_bank_decoder #(
        .p (p),
        .z (z)
    ) u_bank_decoder (
        .memory_index    (lane_nrn),
        .address_package (ap_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            cycle_index     <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            seed_err        <= 1'b0;
            memory_index    <= '0;
            address_package <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == ST_RUN);
            busy      <= (state_d == ST_RUN);
            done      <= fin;
            seed_err  <= load & bad_seed;
            if (load | adv) begin
                base_q          <= base_nxt;
                cycle_index     <= cyc_nxt;
                out_last        <= (cyc_nxt == LAST_C);
                memory_index    <= mi_nxt;
                address_package <= ap_nxt;
            end else if (fin) begin
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_drp_interleaver_stream.sv
// -----------------------------------------------------------------------------
// tb_drp_interleaver_stream
// Self-checking bench for drp_interleaver_stream at the default parameter set
// (fo=2, p=16, z=8, DRP_p=5). The reference model evaluates the DRP formula
// pi(e) = (s + DRP_p*e) mod E directly per lane and derives bank/address from
// the resulting neuron. Honours DRP_DITHER_EN for the expected lane order.
// -----------------------------------------------------------------------------
module tb_drp_interleaver_stream;

    localparam int FO    = 2;
    localparam int P     = 16;
    localparam int Z     = 8;
    localparam int DRP_P = 5;
    localparam int E     = FO * P;
    localparam int C     = E / Z;
    localparam int WP    = 4;
    localparam int WA    = 1;
    localparam int WC    = 2;
    localparam int WS    = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [WS-1:0]   seed;
    logic            out_ready;
    logic            out_valid;
    logic            out_last;
    logic [WC-1:0]   cycle_index;
    logic [WP*Z-1:0] memory_index;
    logic [WA*Z-1:0] address_package;
    logic            busy;
    logic            done;
    logic            seed_err;

    int n_cmp = 0;
    int n_bad = 0;

    drp_interleaver_stream #(
        .fo    (FO),
        .p     (P),
        .z     (Z),
        .DRP_p (DRP_P)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .seed            (seed),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .cycle_index     (cycle_index),
        .memory_index    (memory_index),
        .address_package (address_package),
        .busy            (busy),
        .done            (done),
        .seed_err        (seed_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Neuron expected on output lane l of beat c for offset s.
    function automatic int nrn(input int s, input int c, input int l);
        int src;
        src = l;
`ifdef DRP_DITHER_EN
        src = (l + c) % Z;
`endif
        return ((s + DRP_P * (c * Z + src)) % E) % P;
    endfunction

    function automatic logic [WP*Z-1:0] exp_mi(input int s, input int c);
        logic [WP*Z-1:0] v;
        for (int l = 0; l < Z; l++) v[l*WP +: WP] = WP'(nrn(s, c, l));
        return v;
    endfunction

    function automatic logic [WA*Z-1:0] exp_ap(input int s, input int c);
        logic [WA*Z-1:0] v;
        int n;
        v = '0;
        for (int l = 0; l < Z; l++) begin
            n = nrn(s, c, l);
            v[(n % Z)*WA +: WA] = WA'(n / Z);
        end
        return v;
    endfunction

    function automatic logic [WP*Z-1:0] pack_mi(input int a[Z]);
        logic [WP*Z-1:0] v;
        for (int l = 0; l < Z; l++) v[l*WP +: WP] = WP'(a[l]);
        return v;
    endfunction

    function automatic logic [WA*Z-1:0] pack_ap(input int a[Z]);
        logic [WA*Z-1:0] v;
        for (int b = 0; b < Z; b++) v[b*WA +: WA] = WA'(a[b]);
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; seed = '0; out_ready = 1'b0;
        repeat (3) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%0b exp=0", out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_cmp++; if (seed_err !== 1'b0) begin n_bad++; $display("FAIL reset_seed_err got=%0b exp=0", seed_err); end
        n_cmp++; if (cycle_index !== '0) begin n_bad++; $display("FAIL reset_cycle got=%0d exp=0", cycle_index); end
        n_cmp++; if (memory_index !== '0) begin n_bad++; $display("FAIL reset_mi got=%h exp=0", memory_index); end
        n_cmp++; if (address_package !== '0) begin n_bad++; $display("FAIL reset_ap got=%h exp=0", address_package); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_directed_seed3();
        int c0[Z]  = '{3, 8, 13, 2, 7, 12, 1, 6};
        int a0[Z]  = '{1, 0, 0, 0, 1, 1, 0, 0};
`ifdef DRP_DITHER_EN
        int c1[Z]  = '{0, 5, 10, 15, 4, 9, 14, 11};
`else
        int c1[Z]  = '{11, 0, 5, 10, 15, 4, 9, 14};
`endif
        seed = WS'(3); start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL d_start_valid_busy got=%0b%0b exp=11", out_valid, busy); end
        n_cmp++; if (cycle_index !== WC'(0)) begin n_bad++; $display("FAIL d_cycle0 got=%0d exp=0", cycle_index); end
        n_cmp++; if (memory_index !== pack_mi(c0)) begin n_bad++; $display("FAIL d_mi_c0 got=%h exp=%h", memory_index, pack_mi(c0)); end
        n_cmp++; if (address_package !== pack_ap(a0)) begin n_bad++; $display("FAIL d_ap_c0 got=%h exp=%h", address_package, pack_ap(a0)); end
        n_cmp++; if (seed_err !== 1'b0) begin n_bad++; $display("FAIL d_seed_err got=%0b exp=0", seed_err); end
        step();
        n_cmp++; if (memory_index !== pack_mi(c1)) begin n_bad++; $display("FAIL d_mi_c1 got=%h exp=%h", memory_index, pack_mi(c1)); end
        n_cmp++; if (address_package !== exp_ap(3, 1)) begin n_bad++; $display("FAIL d_ap_c1 got=%h exp=%h", address_package, exp_ap(3, 1)); end
        step();
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL d_last_c2 got=%0b exp=0", out_last); end
        step();
        n_cmp++; if (out_last !== 1'b1 || cycle_index !== WC'(3)) begin n_bad++; $display("FAIL d_last_c3 got=%0b/%0d exp=1/3", out_last, cycle_index); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL d_done_early got=%0b exp=0", done); end
        step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL d_done got=%0b%0b%0b exp=100", done, busy, out_valid); end
        n_cmp++; if (memory_index !== exp_mi(3, 3)) begin n_bad++; $display("FAIL d_hold got=%h exp=%h", memory_index, exp_mi(3, 3)); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL d_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_random_stalls();
        for (int pass = 0; pass < 4; pass++) begin
            int s;
            int got;
            int guard;
            int cnt[P];
            bit stalled;
            logic [WP*Z-1:0] pmi;
            logic [WA*Z-1:0] pap;
            s = $urandom_range(0, E - 1);
            for (int n = 0; n < P; n++) cnt[n] = 0;
            seed = WS'(s); start = 1'b1; out_ready = 1'b0;
            step();
            start = 1'b0;
            n_cmp++; if (seed_err !== 1'b0) begin n_bad++; $display("FAIL r_seed_err s=%0d got=%0b exp=0", s, seed_err); end
            got = 0; guard = 0; stalled = 1'b0; pmi = '0; pap = '0;
            while (got < C && guard < 200) begin
                guard++;
                if (stalled) begin
                    n_cmp++; if (memory_index !== pmi || address_package !== pap) begin n_bad++; $display("FAIL r_stable s=%0d got=%h/%h exp=%h/%h", s, memory_index, address_package, pmi, pap); end
                end
                n_cmp++; if (out_valid !== 1'b1 || cycle_index !== WC'(got) || out_last !== (got == C - 1)) begin
                    n_bad++; $display("FAIL r_ctrl s=%0d c=%0d got=%0b/%0d/%0b", s, got, out_valid, cycle_index, out_last);
                end
                n_cmp++; if (memory_index !== exp_mi(s, got)) begin n_bad++; $display("FAIL r_mi s=%0d c=%0d got=%h exp=%h", s, got, memory_index, exp_mi(s, got)); end
                n_cmp++; if (address_package !== exp_ap(s, got)) begin n_bad++; $display("FAIL r_ap s=%0d c=%0d got=%h exp=%h", s, got, address_package, exp_ap(s, got)); end
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) begin
                    for (int l = 0; l < Z; l++) cnt[int'(memory_index[l*WP +: WP])]++;
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pmi = memory_index;
                    pap = address_package;
                end
                step();
            end
            out_ready = 1'b0;
            n_cmp++; if (got != C) begin n_bad++; $display("FAIL r_timeout s=%0d got=%0d exp=%0d", s, got, C); end
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL r_done s=%0d got=%0b exp=1", s, done); end
            for (int n = 0; n < P; n++) begin
                n_cmp++; if (cnt[n] != FO) begin n_bad++; $display("FAIL r_count s=%0d neuron=%0d got=%0d exp=%0d", s, n, cnt[n], FO); end
            end
            step();
        end
    endtask

    task automatic test_bad_seed();
        int z0[Z] = '{0, 5, 10, 15, 4, 9, 14, 3};
        seed = WS'(40); start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (seed_err !== 1'b1) begin n_bad++; $display("FAIL b_seed_err got=%0b exp=1", seed_err); end
        n_cmp++; if (memory_index !== pack_mi(z0)) begin n_bad++; $display("FAIL b_mi_c0 got=%h exp=%h", memory_index, pack_mi(z0)); end
        for (int c = 0; c < C; c++) begin
            n_cmp++; if (memory_index !== exp_mi(0, c) || address_package !== exp_ap(0, c)) begin
                n_bad++; $display("FAIL b_stream c=%0d got=%h/%h exp=%h/%h", c, memory_index, address_package, exp_mi(0, c), exp_ap(0, c));
            end
            step();
            if (c == 0) begin
                n_cmp++; if (seed_err !== 1'b0) begin n_bad++; $display("FAIL b_seed_err_pulse got=%0b exp=0", seed_err); end
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b_done got=%0b exp=1", done); end
        step();
    endtask

    task automatic test_reset_mid_pass();
        int s;
        s = $urandom_range(0, E - 1);
        seed = WS'(s); start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_cmp++; if (cycle_index !== WC'(2)) begin n_bad++; $display("FAIL m_cycle2 got=%0d exp=2", cycle_index); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL m_ctrl got=%0b%0b%0b%0b exp=0000", out_valid, busy, out_last, done);
        end
        n_cmp++; if (cycle_index !== '0 || memory_index !== '0 || address_package !== '0) begin
            n_bad++; $display("FAIL m_data got=%0d/%h/%h exp=0", cycle_index, memory_index, address_package);
        end
        seed = WS'(7); start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || cycle_index !== WC'(0) || memory_index !== exp_mi(7, 0)) begin
            n_bad++; $display("FAIL m_restart got=%0b/%0d/%h exp=1/0/%h", out_valid, cycle_index, memory_index, exp_mi(7, 0));
        end
        repeat (C) step();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL m_done got=%0b exp=1", done); end
        step();
    endtask

    task automatic test_start_in_run_and_back_to_back();
        int s1;
        int s2;
        s1 = $urandom_range(0, E - 1);
        s2 = (s1 + 11) % E;
        seed = WS'(s1); start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b1; seed = WS'(s2);
        step();
        start = 1'b0;
        n_cmp++; if (cycle_index !== WC'(1) || memory_index !== exp_mi(s1, 1)) begin
            n_bad++; $display("FAIL k_ignore got=%0d/%h exp=1/%h", cycle_index, memory_index, exp_mi(s1, 1));
        end
        step();
        step();
        n_cmp++; if (out_last !== 1'b1 || memory_index !== exp_mi(s1, 3)) begin
            n_bad++; $display("FAIL k_last got=%0b/%h exp=1/%h", out_last, memory_index, exp_mi(s1, 3));
        end
        step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL k_done got=%0b%0b exp=10", done, busy); end
        start = 1'b1; seed = WS'(s2);
        step();
        start = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1 || cycle_index !== WC'(0)) begin
            n_bad++; $display("FAIL k_b2b_ctrl got=%0b%0b/%0d exp=11/0", out_valid, busy, cycle_index);
        end
        n_cmp++; if (memory_index !== exp_mi(s2, 0) || address_package !== exp_ap(s2, 0)) begin
            n_bad++; $display("FAIL k_b2b_data got=%h/%h exp=%h/%h", memory_index, address_package, exp_mi(s2, 0), exp_ap(s2, 0));
        end
        repeat (C) step();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL k_b2b_done got=%0b exp=1", done); end
        step();
    endtask

    initial begin
        test_reset();
        test_directed_seed3();
        test_random_stalls();
        test_bad_seed();
        test_reset_mid_pass();
        test_start_in_run_and_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
